icache_axi_rd_bridge: RTL and testbench

Read-only AXI4 master that sits directly downstream of the instruction cache's refill port. It accepts one outstanding miss or uncached request (`rd_req`/`rd_addr`/`rd_uncache`), issues a single AXI read burst, assembles returned beats into a 128-bit line and hands it back as a single-cycle `ret_valid` pulse. There is no write channel; the block feeds the AXI crossbar.

---
 rtl/icache_axi_rd_bridge.sv | 154 +++++++++++++++
 tb/tb_icache_axi_rd_bridge.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/icache_axi_rd_bridge.sv
// Read-only AXI4 master behind the icache refill port: one outstanding read burst whose beats are assembled into a 128-bit line.
// Optional ICACHE_AXI_RRESP_CHECK_EN enables the rresp / beat-count error flag on ret_err.
module icache_axi_rd_bridge #(
  parameter logic [3:0]  AXI_ID        = 4'd0,
  parameter int unsigned LINE_WORD_NUM = 4
) (
  input  logic         clk_g,
  input  logic         rst,
  input  logic         rd_req,
  input  logic         rd_uncache,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic [127:0] ret_data,
  output logic         ret_err,
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arvalid,
  input  logic         arready,
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_AR   = 2'd1;
  localparam logic [1:0] S_R    = 2'd2;
  localparam logic [1:0] S_RET  = 2'd3;

  localparam logic [7:0] LINE_LEN = 8'(LINE_WORD_NUM - 1);

  logic [1:0]   state_q, state_d;
  logic [31:0]  addr_q, addr_d;
  logic [7:0]   arlen_q, arlen_d;
  logic [127:0] buf_q, buf_d;
  logic [127:0] ret_data_q, ret_data_d;
  logic [127:0] shifted;
  logic         accept;
  logic         beat;

  assign accept  = (state_q == S_IDLE) && rd_req;
  assign beat    = (state_q == S_R) && rvalid;
  // New beat enters at the top; after a full line beat 0 lands in [31:0].
  assign shifted = {rdata, buf_q[127:32]};

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    arlen_d    = arlen_q;
    buf_d      = buf_q;
    ret_data_d = ret_data_q;
    case (state_q)
      S_IDLE: begin
        if (rd_req) begin
          addr_d  = rd_addr;
          arlen_d = rd_uncache ? 8'd0 : LINE_LEN;
          buf_d   = '0;
          state_d = S_AR;
        end
      end
      S_AR: begin
        if (arready) state_d = S_R;
      end
      S_R: begin
        if (rvalid) begin
          buf_d = shifted;
          if (rlast) begin
            ret_data_d = shifted;
            state_d    = S_RET;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_g) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      arlen_q    <= '0;
      buf_q      <= '0;
      ret_data_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      arlen_q    <= arlen_d;
      buf_q      <= buf_d;
      ret_data_q <= ret_data_d;
    end
  end

  assign rd_rdy    = (state_q == S_IDLE);
  assign arvalid   = (state_q == S_AR);
  assign rready    = (state_q == S_R);
  assign ret_valid = (state_q == S_RET);
  assign ret_data  = ret_data_q;
  assign arid      = AXI_ID;
  assign araddr    = addr_q;
  assign arlen     = arlen_q;
  assign arsize    = 3'b010;
  assign arburst   = 2'b01;

`ifdef ICACHE_AXI_RRESP_CHECK_EN
  logic [8:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic [8:0] beat_num, beat_exp;
  logic       unused_rid;

  assign beat_num   = cnt_q + 9'd1;
  assign beat_exp   = {1'b0, arlen_q} + 9'd1;
  assign unused_rid = ^rid;

  // Error is sticky across the burst: bad response, early/late rlast, or surplus beats.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (accept) begin
      cnt_d = '0;
      err_d = 1'b0;
    end else if (beat) begin
      if (cnt_q != '1) cnt_d = beat_num;
      if ((rresp != 2'b00) || (beat_num > beat_exp) || (rlast && (beat_num != beat_exp)))
        err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_g) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign ret_err = (state_q == S_RET) && err_q;
`else
  logic unused_r;
  logic unused_acc;

  assign unused_r   = ^{rid, rresp};
  assign unused_acc = accept ^ beat;
  assign ret_err    = 1'b0;
`endif

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// Scoreboard bench for icache_axi_rd_bridge: driver acts as cache + AXI slave, monitor checks each ret_valid pulse.
module tb_icache_axi_rd_bridge;

  logic         clk_g = 1'b0;
  logic         rst;
  logic         rd_req, rd_uncache;
  logic [31:0]  rd_addr;
  logic         rd_rdy, ret_valid, ret_err;
  logic [127:0] ret_data;
  logic [3:0]   arid, rid;
  logic [31:0]  araddr, rdata;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst, rresp;
  logic         arvalid, arready, rlast, rvalid, rready;

  icache_axi_rd_bridge #(.AXI_ID(4'd0), .LINE_WORD_NUM(4)) dut (
    .clk_g(clk_g), .rst(rst), .rd_req(rd_req), .rd_uncache(rd_uncache), .rd_addr(rd_addr),
    .rd_rdy(rd_rdy), .ret_valid(ret_valid), .ret_data(ret_data), .ret_err(ret_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk_g = ~clk_g;

  int cyc = 0;
  always @(posedge clk_g) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] d;
    logic         e;
    int           c;
  } exp_t;
  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;
  bit prev_hold = 1'b0;
  int prev_ret = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ret_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk_g) begin
    if (!rst && ret_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_ret", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ret_data", ret_data, e.d);
        chk("ret_err", ret_err, e.e);
        chk("ret_cycle", cyc, e.c);
        chk("ret_excl", {rd_rdy, arvalid, rready}, 3'b000);
      end
    end
  end

  task automatic wait_accept(output int t);
    bit got = 1'b0;
    t = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_g);
      if (rd_rdy) begin
        got = 1'b1;
        t = cyc;
        break;
      end
      chk("busy_excl", {rd_rdy, 1'b0}, 2'b00);
      @(posedge clk_g); #1;
    end
    if (!got) begin
      $display("FAIL accept_timeout: rd_rdy never rose");
      miscompares++;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1, "accept timeout");
    end
  endtask

  // Full transaction: nb beats actually returned (rlast on the last one).
  task automatic do_txn(input bit unc, input logic [31:0] addr, input logic [3:0][31:0] w,
                        input logic [3:0][1:0] rs, input int nb, input int ad, input int gap,
                        input bit hold);
    int t;
    exp_t e;
    logic [7:0] exp_len;
    exp_len = unc ? 8'd0 : 8'd3;
    rd_req = 1'b1; rd_uncache = unc; rd_addr = addr;
    wait_accept(t);
    if (prev_hold) chk("hold_accept_cycle", t, prev_ret + 1);
    e.d = '0;
    for (int j = 0; j < nb; j++) e.d[32*(4-nb+j) +: 32] = w[j];
    e.e = 1'b0;
`ifdef ICACHE_AXI_RRESP_CHECK_EN
    for (int j = 0; j < nb; j++) if (rs[j] != 2'b00) e.e = 1'b1;
    if (nb != int'(exp_len) + 1) e.e = 1'b1;
`endif
    e.c = t + 3 + ad + (nb - 1) * (1 + gap);
    sb.push_back(e);
    prev_hold = hold;
    prev_ret = e.c;
    @(posedge clk_g); #1;
    if (!hold) rd_req = 1'b0;
    rd_addr = $urandom;
    rd_uncache = $urandom_range(0, 1);
    arready = (ad == 0);
    for (int c = 0; c <= ad; c++) begin
      @(negedge clk_g);
      chk("ar_fields", {arvalid, rready, rd_rdy, arid, araddr, arlen, arsize, arburst},
          {1'b1, 1'b0, 1'b0, 4'd0, addr, exp_len, 3'b010, 2'b01});
      @(posedge clk_g); #1;
      arready = (c + 1 == ad);
    end
    for (int b = 0; b < nb; b++) begin
      if (b > 0) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk_g);
          chk("r_gap_excl", {arvalid, rready, rd_rdy}, 3'b010);
          @(posedge clk_g); #1;
        end
      end
      rvalid = 1'b1; rdata = w[b]; rresp = rs[b]; rlast = (b == nb - 1); rid = 4'($urandom);
      @(negedge clk_g);
      chk("r_beat_excl", {arvalid, rready, rd_rdy}, 3'b010);
      @(posedge clk_g); #1;
      rvalid = 1'b0; rlast = 1'b0; rdata = $urandom;
    end
  endtask

  logic [3:0][31:0] w;
  logic [3:0][1:0]  rs;
  int t0;

  initial begin
    rst = 1'b1; rd_req = 1'b0; rd_uncache = 1'b0; rd_addr = '0; arready = 1'b0;
    rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    repeat (3) @(posedge clk_g);
    @(negedge clk_g);
    chk("reset_ctrl", {rd_rdy, arvalid, rready, ret_valid, ret_err}, 5'b10000);
    chk("reset_data", ret_data, '0);
    chk("reset_ar", {araddr, arlen}, 40'd0);
    @(posedge clk_g); #1;
    rst = 1'b0;

    w = {32'h44, 32'h33, 32'h22, 32'h11}; rs = '0;
    do_txn(1'b0, 32'h1FC0_0010, w, rs, 4, 0, 0, 1'b0);
    w = {96'd0, 32'hDEADBEEF};
    do_txn(1'b1, 32'hBFC0_0004, w, rs, 1, 0, 0, 1'b0);
    w = {32'hA4, 32'hA3, 32'hA2, 32'hA1};
    do_txn(1'b0, 32'h0000_1230, w, rs, 4, 3, 2, 1'b0);
    w = {32'hB4, 32'hB3, 32'hB2, 32'hB1};
    do_txn(1'b0, 32'h8000_0040, w, rs, 4, 1, 0, 1'b1);
    w = {96'd0, 32'hC0FFEE00};
    do_txn(1'b1, 32'h8000_0048, w, rs, 1, 0, 1, 1'b0);

    // Reset in the middle of the second beat of a refill.
    rd_req = 1'b1; rd_uncache = 1'b0; rd_addr = 32'h0000_2000;
    wait_accept(t0);
    @(posedge clk_g); #1;
    rd_req = 1'b0; arready = 1'b1;
    @(posedge clk_g); #1;
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h5555_0000;
    @(posedge clk_g); #1;
    rdata = 32'h5555_0001; rst = 1'b1;
    @(posedge clk_g); #1;
    rvalid = 1'b0; rst = 1'b0;
    @(negedge clk_g);
    chk("midrst_ctrl", {rd_rdy, arvalid, rready, ret_valid, ret_err}, 5'b10000);
    chk("midrst_data", ret_data, '0);
    @(posedge clk_g); #1;
    prev_hold = 1'b0;
    w = {32'hD4, 32'hD3, 32'hD2, 32'hD1};
    do_txn(1'b0, 32'h0000_2000, w, rs, 4, 0, 0, 1'b0);

    // Error response on beat 1, then a clean burst.
    rs = {2'b00, 2'b00, 2'b10, 2'b00};
    w = {32'hE4, 32'hE3, 32'hE2, 32'hE1};
    do_txn(1'b0, 32'h0000_3000, w, rs, 4, 0, 0, 1'b0);
    rs = '0;
    w = {32'hF4, 32'hF3, 32'hF2, 32'hF1};
    do_txn(1'b0, 32'h0000_3010, w, rs, 4, 0, 0, 1'b0);
    // Early rlast: two beats for a four-beat refill.
    w = {32'h0, 32'h0, 32'h6602, 32'h6601};
    do_txn(1'b0, 32'h0000_4000, w, rs, 2, 0, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      bit unc;
      unc = $urandom_range(0, 1);
      for (int j = 0; j < 4; j++) begin
        w[j] = $urandom;
        rs[j] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      end
      do_txn(unc, unc ? ($urandom & 32'hFFFF_FFFC) : ($urandom & 32'hFFFF_FFF0), w, rs,
             unc ? 1 : 4, $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
    rd_req = 1'b0;
    repeat (8) @(posedge clk_g);
    @(negedge clk_g);
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

endmodule
